axi_tlb_miss_log: RTL and testbench

Captures every translation miss routed to the TLB's error-slave branch into a bounded FIFO for software inspection. Sits directly downstream of the TLB demultiplexer's miss output, in parallel with the error slave. It passively taps the error-slave AW and AR handshakes and never back-pressures them. Logged entries (address, ID, direction) are drained through a valid/ready pop port. A saturating overflow counter and a level interrupt let a miss handler find, replay or report faulting accesses.

---
 rtl/axi_tlb_miss_log.sv | 107 ++++++++++
 tb/tb_axi_tlb_miss_log.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_tlb_miss_log.sv
// Passive logger of translation misses tapped from the error-slave AW/AR handshakes.
// Misses are kept in a small circular FIFO; drops are tallied in a saturating counter.
module axi_tlb_miss_log #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 aw_valid_i,
  input  logic                 aw_ready_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 ar_valid_i,
  input  logic                 ar_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  output logic                 log_valid_o,
  input  logic                 log_ready_i,
  output logic [AddrWidth-1:0] log_addr_o,
  output logic [IdWidth-1:0]   log_id_o,
  output logic                 log_write_o,
  output logic [CntWidth-1:0]  overflow_cnt_o,
  output logic                 irq_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned EntW = AddrWidth + IdWidth + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [EntW-1:0]     mem [Depth];
  ptr_t                rd_ptr, wr_ptr, wr_ptr_nxt, ar_slot;
  cnt_t                count;
  logic [CntWidth-1:0] ovf_cnt;

  logic       aw_evt, ar_evt, aw_acc, ar_acc, has1, has2, pop;
  logic [1:0] n_acc, n_drop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(Depth - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [1:0]          b);
    logic [CntWidth:0] s;
    s = {1'b0, a} + {{(CntWidth-1){1'b0}}, b};
    if (s[CntWidth]) return '1;
    return s[CntWidth-1:0];
  endfunction

  // Free space judged on the registered count only; a same-cycle pop frees nothing.
  always_comb begin
    aw_evt  = aw_valid_i & aw_ready_i;
    ar_evt  = ar_valid_i & ar_ready_i;
    has1    = (count != cnt_t'(Depth));
    has2    = (count <= cnt_t'(Depth - 2));
    aw_acc  = aw_evt & has1;
    ar_acc  = ar_evt & (aw_evt ? has2 : has1);
    n_acc   = {1'b0, aw_acc} + {1'b0, ar_acc};
    n_drop  = {1'b0, aw_evt & ~aw_acc} + {1'b0, ar_evt & ~ar_acc};
    ar_slot = aw_acc ? ptr_inc(wr_ptr) : wr_ptr;
    pop     = (count != '0) & log_ready_i;
    wr_ptr_nxt = wr_ptr;
    if (n_acc == 2'd2)      wr_ptr_nxt = ptr_inc(ptr_inc(wr_ptr));
    else if (n_acc == 2'd1) wr_ptr_nxt = ptr_inc(wr_ptr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ovf_cnt <= '0;
    end else if (clear_i) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ovf_cnt <= '0;
    end else begin
      count   <= count + cnt_t'(n_acc) - cnt_t'(pop);
      wr_ptr  <= wr_ptr_nxt;
      ovf_cnt <= sat_add(ovf_cnt, n_drop);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Entry storage carries no reset; AW takes the older slot when both arrive.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (aw_acc) mem[wr_ptr]  <= {1'b1, aw_id_i, aw_addr_i};
      if (ar_acc) mem[ar_slot] <= {1'b0, ar_id_i, ar_addr_i};
    end
  end

  assign log_valid_o    = (count != '0);
  assign {log_write_o, log_id_o, log_addr_o} = mem[rd_ptr];
  assign overflow_cnt_o = ovf_cnt;
  assign irq_o          = (count != '0) | (ovf_cnt != '0);

endmodule

// File: tb/tb_axi_tlb_miss_log.sv
// Bench for axi_tlb_miss_log: queue-based reference model plus directed vectors.
module tb_axi_tlb_miss_log;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int DP = 4;

  logic clk, rst_n, clr;
  logic aw_v, aw_r, ar_v, ar_r, rdy;
  logic [AW-1:0] aw_a, ar_a;
  logic [IW-1:0] aw_i, ar_i;

  logic          lv, lw, irq, lv_s, lw_s, irq_s;
  logic [AW-1:0] la, la_s;
  logic [IW-1:0] li, li_s;
  logic [15:0]   ovf;
  logic [1:0]    ovf_s;

  int nvec = 0;
  int nerr = 0;

  axi_tlb_miss_log #(.AddrWidth(AW), .IdWidth(IW), .Depth(DP), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .aw_valid_i(aw_v), .aw_ready_i(aw_r), .aw_addr_i(aw_a), .aw_id_i(aw_i),
    .ar_valid_i(ar_v), .ar_ready_i(ar_r), .ar_addr_i(ar_a), .ar_id_i(ar_i),
    .log_valid_o(lv), .log_ready_i(rdy), .log_addr_o(la), .log_id_o(li),
    .log_write_o(lw), .overflow_cnt_o(ovf), .irq_o(irq));

  axi_tlb_miss_log #(.AddrWidth(AW), .IdWidth(IW), .Depth(DP), .CntWidth(2)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .aw_valid_i(aw_v), .aw_ready_i(aw_r), .aw_addr_i(aw_a), .aw_id_i(aw_i),
    .ar_valid_i(ar_v), .ar_ready_i(ar_r), .ar_addr_i(ar_a), .ar_id_i(ar_i),
    .log_valid_o(lv_s), .log_ready_i(rdy), .log_addr_o(la_s), .log_id_o(li_s),
    .log_write_o(lw_s), .overflow_cnt_o(ovf_s), .irq_o(irq_s));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          wr;
  } ent_t;

  ent_t mq[$];
  int   movf;
  int   mfree;
  bit   mhad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue with Depth slots, AW offered before AR, unbounded drop tally.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      movf = 0;
    end else if (clr) begin
      mq.delete();
      movf = 0;
    end else begin
      mhad  = (mq.size() != 0);
      mfree = DP - mq.size();
      if (aw_v && aw_r) begin
        if (mfree > 0) begin mq.push_back('{aw_a, aw_i, 1'b1}); mfree--; end
        else movf++;
      end
      if (ar_v && ar_r) begin
        if (mfree > 0) begin mq.push_back('{ar_a, ar_i, 1'b0}); mfree--; end
        else movf++;
      end
      if (mhad && rdy) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'd0, lv}, {31'd0, mq.size() != 0});
    chk("valid_s", {31'd0, lv_s}, {31'd0, mq.size() != 0});
    chk("ovf", {16'd0, ovf}, (movf > 65535) ? 32'd65535 : 32'(movf));
    chk("ovf_s", {30'd0, ovf_s}, (movf > 3) ? 32'd3 : 32'(movf));
    chk("irq", {31'd0, irq}, {31'd0, (mq.size() != 0) || (movf != 0)});
    chk("irq_s", {31'd0, irq_s}, {31'd0, (mq.size() != 0) || (movf != 0)});
    if (mq.size() != 0) begin
      chk("head", {11'd0, lw, li, la}, {11'd0, mq[0].wr, mq[0].id, mq[0].addr});
      chk("head_s", {11'd0, lw_s, li_s, la_s}, {11'd0, mq[0].wr, mq[0].id, mq[0].addr});
    end
  end

  task automatic cyc(input logic awv, input logic awr, input logic [AW-1:0] awa,
                     input logic [IW-1:0] awi, input logic arv, input logic arr,
                     input logic [AW-1:0] ara, input logic [IW-1:0] ari,
                     input logic rd, input logic c);
    aw_v = awv; aw_r = awr; aw_a = awa; aw_i = awi;
    ar_v = arv; ar_r = arr; ar_a = ara; ar_i = ari;
    rdy = rd; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rd);
    cyc(0, 0, '0, '0, 0, 0, '0, '0, rd, 0);
  endtask

  task automatic aw1(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic rd);
    cyc(1, 1, a, i, 0, 0, '0, '0, rd, 0);
  endtask

  task automatic ar1(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic rd);
    cyc(0, 0, '0, '0, 1, 1, a, i, rd, 0);
  endtask

  initial begin
    rst_n = 0; clr = 0; rdy = 0;
    aw_v = 0; aw_r = 0; aw_a = '0; aw_i = '0;
    ar_v = 0; ar_r = 0; ar_a = '0; ar_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_valid", {31'd0, lv}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ovf", {16'd0, ovf}, 32'd0);

    // Single AW miss held at the head
    aw1(16'h1234, 4'd3, 0);
    chk("aw_valid", {31'd0, lv}, 32'd1);
    chk("aw_addr", {16'd0, la}, 32'h1234);
    chk("aw_id", {28'd0, li}, 32'd3);
    chk("aw_write", {31'd0, lw}, 32'd1);
    chk("aw_irq", {31'd0, irq}, 32'd1);
    idle(0); idle(0);
    chk("aw_hold", {16'd0, la}, 32'h1234);
    idle(1);
    chk("pop_valid", {31'd0, lv}, 32'd0);
    chk("pop_irq", {31'd0, irq}, 32'd0);

    // Simultaneous AW/AR: AW is older
    cyc(1, 1, 16'hA, 4'd1, 1, 1, 16'hB, 4'd2, 0, 0);
    chk("dual_head", {16'd0, la}, 32'hA);
    chk("dual_wr", {31'd0, lw}, 32'd1);
    idle(1);
    chk("dual_second", {16'd0, la}, 32'hB);
    chk("dual_rd", {31'd0, lw}, 32'd0);
    idle(1);
    chk("dual_empty", {31'd0, lv}, 32'd0);

    // Three held, AW+AR with pop: AR dropped, count stays 3
    aw1(16'd1, 4'd1, 0); aw1(16'd2, 4'd2, 0); aw1(16'd3, 4'd3, 0);
    cyc(1, 1, 16'd4, 4'd4, 1, 1, 16'd5, 4'd5, 1, 0);
    chk("three_ovf", {16'd0, ovf}, 32'd1);
    chk("three_head", {16'd0, la}, 32'd2);
    idle(1); idle(1);
    chk("three_last", {16'd0, la}, 32'd4);
    idle(1);
    chk("three_empty", {31'd0, lv}, 32'd0);
    cyc(0, 0, '0, '0, 0, 0, '0, '0, 0, 1);
    chk("clr_ovf", {16'd0, ovf}, 32'd0);

    // Fill, then five AR drops; 2-bit counter saturates
    for (int k = 0; k < DP; k++) aw1(AW'(16'h10 + k), IW'(k), 0);
    for (int k = 0; k < 5; k++) ar1(AW'(16'h20 + k), 4'hF, 0);
    chk("drop5", {16'd0, ovf}, 32'd5);
    chk("drop5_sat", {30'd0, ovf_s}, 32'd3);
    chk("drop5_irq_s", {31'd0, irq_s}, 32'd1);
    chk("drop5_head", {16'd0, la}, 32'h10);

    // Clear with FIFO full, overflow 2 and a same-cycle AW
    cyc(0, 0, '0, '0, 0, 0, '0, '0, 0, 1);
    for (int k = 0; k < DP; k++) aw1(AW'(16'h30 + k), IW'(k), 0);
    ar1(16'h40, 4'd0, 0); ar1(16'h41, 4'd0, 0);
    chk("pre_clr_ovf", {16'd0, ovf}, 32'd2);
    cyc(1, 1, 16'h50, 4'd5, 0, 0, '0, '0, 1, 1);
    chk("clr_valid", {31'd0, lv}, 32'd0);
    chk("clr_ovf2", {16'd0, ovf}, 32'd0);
    chk("clr_irq", {31'd0, irq}, 32'd0);

    // Stalled AW is never logged
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 16'h77, 4'd7, 0, 0, '0, '0, 0, 0);
      chk("stall_valid", {31'd0, lv}, 32'd0);
    end
    cyc(1, 1, 16'h60, 4'd6, 1, 1, 16'h61, 4'd6, 0, 0);
    chk("prerst_valid", {31'd0, lv}, 32'd1);
    idle(0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'd0, lv}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_ovf", {16'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(0);

    // Sustained single stream with continuous pop, wrapping the pointers
    for (int k = 0; k < 12; k++) aw1(AW'(16'h100 + k), IW'(k), 1);
    idle(1);
    chk("stream_ovf", {16'd0, ovf}, 32'd0);

    // Mixed traffic, model-checked every cycle
    for (int k = 0; k < 40; k++) begin
      cyc(k[0], 1'b1, AW'(16'h200 + k), IW'(k), k[1] ^ k[2], 1'b1, AW'(16'h300 + k), IW'(k + 1),
          k[0] & k[3], (k == 30));
    end
    idle(1); idle(1); idle(1); idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
